// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute control FSM driving program_counter and the SIMD datapath.
// Build option: define SEQ_TIMEOUT_EN to add the EXEC watchdog and sticky err flag.
module instr_sequencer #(
    parameter int OPCODE_LEN  = 4,
    parameter int PC_WIDTH    = 12,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  instr_valid,
    input  logic [OPCODE_LEN-1:0] opcode,
    input  logic [PC_WIDTH-1:0]   target,
    input  logic                  zero_flag,
    input  logic                  dp_done,
    output logic                  pc_inc,
    output logic                  pc_load,
    output logic [PC_WIDTH-1:0]   pc_target,
    output logic                  dp_start,
    output logic [OPCODE_LEN-1:0] dp_opcode,
    output logic                  busy,
    output logic                  halted,
    output logic                  err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    localparam logic [OPCODE_LEN-1:0] OP_NOP  = OPCODE_LEN'(4'h0);
    localparam logic [OPCODE_LEN-1:0] OP_JMP  = OPCODE_LEN'(4'h8);
    localparam logic [OPCODE_LEN-1:0] OP_BEQZ = OPCODE_LEN'(4'h9);
    localparam logic [OPCODE_LEN-1:0] OP_HALT = OPCODE_LEN'(4'hF);

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [OPCODE_LEN-1:0] r_opcode;
    logic [PC_WIDTH-1:0]   r_target;
    logic                  r_pc_inc;
    logic                  r_pc_load;
    logic [PC_WIDTH-1:0]   r_pc_target;
    logic                  r_dp_start;
    logic [OPCODE_LEN-1:0] r_dp_opcode;

    logic                  w_pc_inc_nxt;
    logic                  w_pc_load_nxt;
    logic [PC_WIDTH-1:0]   w_pc_target_nxt;
    logic                  w_dp_start_nxt;
    logic [OPCODE_LEN-1:0] w_dp_opcode_nxt;

    logic w_capture;
    logic w_is_nop;
    logic w_is_jmp;
    logic w_is_beqz;
    logic w_is_halt;
    logic w_is_vec;
    logic w_timeout;

    assign w_capture = (r_state == S_FETCH) && instr_valid;

    assign w_is_nop  = (r_opcode == OP_NOP);
    assign w_is_jmp  = (r_opcode == OP_JMP);
    assign w_is_beqz = (r_opcode == OP_BEQZ);
    assign w_is_halt = (r_opcode == OP_HALT);
    assign w_is_vec  = !(w_is_nop || w_is_jmp || w_is_beqz || w_is_halt);

`ifdef SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_err;

    // Counter holds the 1-based EXEC cycle index; a dp_done on the last cycle still wins.
    assign w_timeout = (r_state == S_EXEC) && !dp_done &&
                       (r_wd_cnt == WD_W'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if ((r_state == S_DECODE) && w_is_vec) begin
                r_wd_cnt <= WD_W'(1);
            end else if ((r_state == S_EXEC) && !dp_done && !w_timeout) begin
                r_wd_cnt <= r_wd_cnt + WD_W'(1);
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    // Without the watchdog err can never be raised.
    assign err = (TIMEOUT_CYC < 0);
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_inc_nxt    = 1'b0;
        w_pc_load_nxt   = 1'b0;
        w_pc_target_nxt = r_pc_target;
        w_dp_start_nxt  = 1'b0;
        w_dp_opcode_nxt = r_dp_opcode;
        case (r_state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (instr_valid) begin
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                w_state_nxt = S_FETCH;
                unique case (1'b1)
                    w_is_nop: begin
                        w_pc_inc_nxt = 1'b1;
                    end
                    w_is_jmp: begin
                        w_pc_load_nxt   = 1'b1;
                        w_pc_target_nxt = r_target;
                    end
                    w_is_beqz: begin
                        if (zero_flag) begin
                            w_pc_load_nxt   = 1'b1;
                            w_pc_target_nxt = r_target;
                        end else begin
                            w_pc_inc_nxt = 1'b1;
                        end
                    end
                    w_is_halt: begin
                        w_state_nxt = S_HALTED;
                    end
                    w_is_vec: begin
                        w_dp_start_nxt  = 1'b1;
                        w_dp_opcode_nxt = r_opcode;
                        w_state_nxt     = S_EXEC;
                    end
                    default: begin
                        w_state_nxt = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                if (dp_done) begin
                    w_pc_inc_nxt = 1'b1;
                    w_state_nxt  = S_FETCH;
                end else if (w_timeout) begin
                    w_state_nxt = S_HALTED;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_opcode    <= '0;
            r_target    <= '0;
            r_pc_inc    <= 1'b0;
            r_pc_load   <= 1'b0;
            r_pc_target <= '0;
            r_dp_start  <= 1'b0;
            r_dp_opcode <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc_inc    <= w_pc_inc_nxt;
            r_pc_load   <= w_pc_load_nxt;
            r_pc_target <= w_pc_target_nxt;
            r_dp_start  <= w_dp_start_nxt;
            r_dp_opcode <= w_dp_opcode_nxt;
            if (w_capture) begin
                r_opcode <= opcode;
                r_target <= target;
            end
        end
    end

    assign pc_inc    = r_pc_inc;
    assign pc_load   = r_pc_load;
    assign pc_target = r_pc_target;
    assign dp_start  = r_dp_start;
    assign dp_opcode = r_dp_opcode;
    assign busy      = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                       (r_state == S_EXEC);
    assign halted    = (r_state == S_HALTED);

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed table, hand sequences and a randomized
// program run against a transaction-level model of instr_sequencer.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        instr_valid = 1'b0;
    logic [3:0]  opcode = '0;
    logic [11:0] target = '0;
    logic        zero_flag = 1'b0;
    logic        dp_done = 1'b0;
    logic        pc_inc;
    logic        pc_load;
    logic [11:0] pc_target;
    logic        dp_start;
    logic [3:0]  dp_opcode;
    logic        busy;
    logic        halted;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_sequencer #(
        .OPCODE_LEN (4),
        .PC_WIDTH   (12),
        .TIMEOUT_CYC(64)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .instr_valid(instr_valid),
        .opcode     (opcode),
        .target     (target),
        .zero_flag  (zero_flag),
        .dp_done    (dp_done),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .dp_start   (dp_start),
        .dp_opcode  (dp_opcode),
        .busy       (busy),
        .halted     (halted),
        .err        (err)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_inc"}, pc_inc, 0);
        chk({nm, "_load"}, pc_load, 0);
        chk({nm, "_tgt"}, pc_target, 0);
        chk({nm, "_start"}, dp_start, 0);
        chk({nm, "_dop"}, dp_opcode, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_halted"}, halted, 0);
        chk({nm, "_err"}, err, 0);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [11:0] tg;
        logic        zf;
        logic        e_inc;
        logic        e_load;
        logic        e_start;
        logic        e_halt;
    } vec_t;

    vec_t tv [9];

    localparam int NR = 3000;
    localparam int NA = NR + 16;

    bit          einc   [NA];
    bit          eload  [NA];
    bit          estart [NA];
    bit          ebusy  [NA];
    bit          ehalt  [NA];
    bit          zf_a   [NA];
    logic [11:0] etgt   [NA];
    logic [3:0]  edop   [NA];
    logic [3:0]  mem_op [4096];
    logic [11:0] mem_tg [4096];

    task automatic run_table();
        for (int i = 0; i < 9; i++) begin
            instr_valid = 1'b1;
            opcode      = tv[i].op;
            target      = tv[i].tg;
            zero_flag   = !tv[i].zf;
            @(negedge clk);
            chk("tbl_dec_busy", busy, 1);
            chk("tbl_dec_inc", pc_inc, 0);
            chk("tbl_dec_load", pc_load, 0);
            instr_valid = 1'b0;
            zero_flag   = tv[i].zf;
            opcode      = 4'($urandom);
            target      = 12'($urandom);
            @(negedge clk);
            chk("tbl_inc", pc_inc, tv[i].e_inc);
            chk("tbl_load", pc_load, tv[i].e_load);
            chk("tbl_start", dp_start, tv[i].e_start);
            chk("tbl_halted", halted, tv[i].e_halt);
            if (tv[i].e_load) chk("tbl_tgt", pc_target, tv[i].tg);
            if (tv[i].e_start) chk("tbl_dop", dp_opcode, tv[i].op);
            zero_flag = 1'b0;
            if (tv[i].e_start) begin
                for (int k = 1; k <= 5; k++) begin
                    @(negedge clk);
                    chk("tbl_exec_start", dp_start, 0);
                    chk("tbl_exec_inc", pc_inc, 0);
                    chk("tbl_exec_dop", dp_opcode, tv[i].op);
                end
                dp_done = 1'b1;
                @(negedge clk);
                dp_done = 1'b0;
                chk("tbl_done_inc", pc_inc, 1);
                chk("tbl_done_busy", busy, 1);
            end else if (tv[i].e_halt) begin
                chk("tbl_halt_busy", busy, 0);
                chk("tbl_halt_inc", pc_inc, 0);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("tbl_restart_busy", busy, 1);
                chk("tbl_restart_halted", halted, 0);
            end
        end
    endtask

    task automatic issue_vec(input logic [3:0] op);
        instr_valid = 1'b1;
        opcode      = op;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("vec_start", dp_start, 1);
        chk("vec_dop", dp_opcode, op);
    endtask

    task automatic run_random();
        int          nf;
        int          done_at;
        int          xlo;
        int          lat;
        int          sel;
        logic [11:0] pc;
        logic [3:0]  op;
        logic [11:0] tg;
        bit          v;
        for (int k = 0; k < NA; k++) begin
            einc[k] = 0; eload[k] = 0; estart[k] = 0;
            ebusy[k] = 0; ehalt[k] = 0; etgt[k] = '0; edop[k] = '0;
            zf_a[k] = 1'($urandom);
        end
        for (int a = 0; a < 4096; a++) begin
            sel = int'($urandom_range(0, 7));
            mem_tg[a] = 12'($urandom);
            case (sel)
                0, 1:    mem_op[a] = 4'h0;
                2:       mem_op[a] = 4'h8;
                3, 4:    mem_op[a] = 4'h9;
                5:       mem_op[a] = 4'hF;
                default: begin
                    mem_op[a] = 4'($urandom_range(1, 14));
                    if (mem_op[a] == 4'h8 || mem_op[a] == 4'h9) mem_op[a] = mem_op[a] + 4'h2;
                end
            endcase
        end
        nf = -1; done_at = -1; xlo = -1; pc = '0;
        start = 0; instr_valid = 0; dp_done = 0; zero_flag = 0;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < NR; c++) begin
            @(negedge clk);
            chk("rnd_inc", pc_inc, einc[c]);
            chk("rnd_load", pc_load, eload[c]);
            chk("rnd_start", dp_start, estart[c]);
            chk("rnd_dop", dp_opcode, edop[c]);
            chk("rnd_busy", busy, ebusy[c]);
            chk("rnd_halted", halted, ehalt[c]);
            chk("rnd_err", err, 0);
            if (eload[c]) chk("rnd_tgt", pc_target, etgt[c]);
            start = ($urandom_range(0, 3) == 0);
            if (start && !ebusy[c]) begin
                for (int k = c + 1; k < NA; k++) begin
                    ebusy[k] = 1; ehalt[k] = 0;
                end
                nf = c + 1;
            end
            v = ($urandom_range(0, 3) != 0);
            if (v) begin
                op = mem_op[pc]; tg = mem_tg[pc];
            end else begin
                op = 4'($urandom); tg = 12'($urandom);
            end
            instr_valid = v; opcode = op; target = tg; zero_flag = zf_a[c];
            if (v && nf >= 0 && c >= nf) begin
                nf = -1;
                case (op)
                    4'h0: begin einc[c+2] = 1; pc = pc + 1; nf = c + 2; end
                    4'h8: begin eload[c+2] = 1; etgt[c+2] = tg; pc = tg; nf = c + 2; end
                    4'h9: begin
                        if (zf_a[c+1]) begin
                            eload[c+2] = 1; etgt[c+2] = tg; pc = tg;
                        end else begin
                            einc[c+2] = 1; pc = pc + 1;
                        end
                        nf = c + 2;
                    end
                    4'hF: begin
                        for (int k = c + 2; k < NA; k++) begin
                            ebusy[k] = 0; ehalt[k] = 1;
                        end
                    end
                    default: begin
                        estart[c+2] = 1;
                        for (int k = c + 2; k < NA; k++) edop[k] = op;
                        lat = int'($urandom_range(1, 6));
                        xlo = c + 2;
                        done_at = c + 2 + lat;
                        einc[done_at+1] = 1;
                        pc = pc + 1;
                        nf = done_at + 1;
                    end
                endcase
            end
            dp_done = (c == done_at) ||
                      (!(c >= xlo && c <= done_at) && $urandom_range(0, 7) == 0);
        end
        start = 0; instr_valid = 0; dp_done = 0;
    endtask

    initial begin
        tv[0] = '{4'h0, 12'h123, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[1] = '{4'h8, 12'h0A5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[2] = '{4'h9, 12'h010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[3] = '{4'h9, 12'h010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[4] = '{4'h3, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[5] = '{4'hF, 12'h7FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[6] = '{4'hE, 12'h000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[7] = '{4'h0, 12'hABC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[8] = '{4'h8, 12'hFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        rstn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom); instr_valid = 1'($urandom);
            opcode = 4'($urandom); target = 12'($urandom);
            zero_flag = 1'($urandom); dp_done = 1'($urandom);
            @(negedge clk);
            chk_zero("rst");
        end
        start = 1'b0;
        rstn  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_halted", halted, 0);
            chk("idle_inc", pc_inc, 0);
        end
        instr_valid = 1'b0; dp_done = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1);

        run_table();

        instr_valid = 1'b1;
        opcode      = 4'h0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("nop_inc", pc_inc, (i % 2 == 0));
            chk("nop_load", pc_load, 0);
            chk("nop_busy", busy, 1);
        end
        instr_valid = 1'b0;

        dp_done = 1'b1;
        @(negedge clk);
        dp_done = 1'b0;
        chk("spur_inc", pc_inc, 0);
        chk("spur_start", dp_start, 0);
        chk("spur_busy", busy, 1);
        @(negedge clk);
        chk("spur_inc2", pc_inc, 0);

`ifdef SEQ_TIMEOUT_EN
        issue_vec(4'h5);
        for (int k = 2; k <= 64; k++) @(negedge clk);
        dp_done = 1'b1;
        @(negedge clk);
        dp_done = 1'b0;
        chk("tie_inc", pc_inc, 1);
        chk("tie_err", err, 0);
        chk("tie_busy", busy, 1);
        issue_vec(4'h5);
        for (int k = 2; k <= 64; k++) @(negedge clk);
        chk("wd_busy", busy, 1);
        chk("wd_err0", err, 0);
        @(negedge clk);
        chk("wd_err", err, 1);
        chk("wd_halted", halted, 1);
        chk("wd_inc", pc_inc, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("wd_restart", busy, 1);
        chk("wd_sticky", err, 1);
`else
        issue_vec(4'h5);
        for (int k = 2; k <= 100; k++) @(negedge clk);
        chk("long_busy", busy, 1);
        chk("long_err", err, 0);
        chk("long_halted", halted, 0);
        dp_done = 1'b1;
        @(negedge clk);
        dp_done = 1'b0;
        chk("long_inc", pc_inc, 1);
        chk("long_err2", err, 0);
`endif

        issue_vec(4'h6);
        #2 rstn = 1'b0;
        #1 chk_zero("midrst");
        @(negedge clk);
        rstn    = 1'b1;
        dp_done = 1'b1;
        @(negedge clk);
        dp_done = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_inc", pc_inc, 0);
        chk("midrst_err", err, 0);

        run_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
